// File: rtl/rca_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package rca_seq_pkg;

   // Width of one pass through the rca4 datapath.
   localparam int unsigned NIB_W = 4;

   // Sequencer states; encoding kept identical to the legacy 2-bit values.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Nibble index counter width: clog2(nibbles), never below one bit.
   function automatic int unsigned idx_width(input int unsigned nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/rca4.sv
// 4-bit gate-level ripple-carry adder used as the sequencer's datapath.
module rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] w_c;

   assign w_c[0] = ci;

   // One full adder per bit, carry rippling upward.
   for (genvar g = 0; g < 4; g++) begin : g_fa
      logic w_p;
      assign w_p        = a[g] ^ b[g];
      assign s[g]       = w_p ^ w_c[g];
      assign w_c[g + 1] = (a[g] & b[g]) | (w_p & w_c[g]);
   end

   assign co = w_c[4];

endmodule

// File: rtl/rca4_serial_seq.sv
// Performs WIDTH-bit additions by driving one rca4 a nibble per clock.
module rca4_serial_seq
   import rca_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NIBBLES = WIDTH / NIB_W;
   localparam int unsigned IDX_W   = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("rca4_serial_seq: WIDTH must be a non-zero multiple of 4");
   end

   state_e             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_work;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [IDX_W-1:0]   r_idx;

   logic [NIB_W-1:0]   w_a;
   logic [NIB_W-1:0]   w_b;
   logic [NIB_W-1:0]   w_s;
   logic               w_co;
   logic [WIDTH-1:0]   w_sum_next;
   logic               w_ovf_next;

   // Select the operand nibbles addressed by the current index.
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (r_idx == IDX_W'(n)) begin
            w_a = r_a[n*NIB_W +: NIB_W];
            w_b = r_b[n*NIB_W +: NIB_W];
         end
      end
   end

   rca4 u_rca4 (
      .a  (w_a),
      .b  (w_b),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Merge the fresh nibble into the partial sum; kept apart from the
   // operand mux so the adder sits between two independent comb blocks.
   always_comb begin
      w_sum_next = r_work;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (r_idx == IDX_W'(n)) begin
            w_sum_next[n*NIB_W +: NIB_W] = w_s;
         end
      end
   end

   assign w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);

   // Sequencer: accept operands, run one nibble per edge, hold the result.
   // The partial sum lives in r_work so the visible result only moves on
   // the final capture and otherwise keeps the previous answer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_carry <= c_in;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_work  <= w_sum_next;
               r_carry <= w_co;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_sum   <= w_sum_next;
                  r_cout  <= w_co;
                  r_ovf   <= w_ovf_next;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign sum_out   = r_sum;
   assign c_out     = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca4_serial_seq.sv
// Directed scoreboard bench for rca4_serial_seq at WIDTH=16.
module tb_rca4_serial_seq;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum_out;
   logic         c_out;
   logic         ovf;
   logic         busy;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   rca4_serial_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .c_out     (c_out),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t       e;
      logic [W:0] t;
      t    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.sum = t[W-1:0];
      e.co  = t[W];
      e.ov  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   // Present operands, wait for in_ready, push the expectation, accept.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n = 0;
      a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("issue_ready", {31'd0, in_ready}, 32'd1);
      sb.push_back(model(a, b, c));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("run_busy", {31'd0, busy}, 32'd1);
      check("run_in_ready", {31'd0, in_ready}, 32'd0);
   endtask

   // Wait for the result, compare against the scoreboard, hand it off.
   task automatic collect(input string tag, input bit chk_lat);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      if (chk_lat) check({tag, "_latency"}, n, 32'd4);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_sum"}, {16'd0, sum_out}, {16'd0, e.sum});
         check({tag, "_cout"}, {31'd0, c_out}, {31'd0, e.co});
         check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] held_sum;
      exp_t         e;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rst_sum", {16'd0, sum_out}, 32'd0);
      check("rst_cout", {31'd0, c_out}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      issue(16'h1234, 16'h4321, 1'b0); collect("op_5555", 1'b1);
      issue(16'hFFFF, 16'h0001, 1'b0); collect("op_ripple", 1'b1);
      issue(16'h7FFF, 16'h0001, 1'b0); collect("op_posovf", 1'b1);
      issue(16'h8000, 16'h8000, 1'b0); collect("op_negovf", 1'b1);
      issue(16'h0000, 16'hFFFF, 1'b1); collect("op_cin", 1'b1);

      // Back-pressure with a competing operand presented during DONE.
      issue(16'h0F0F, 16'h0101, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      held_sum = sum_out;
      check("bp_sum_first", {16'd0, held_sum}, 32'h1010);
      a_in = 16'h00AA; b_in = 16'h0055; c_in = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_sum", {16'd0, sum_out}, {16'd0, held_sum});
         check("bp_hold_busy", {31'd0, busy}, 32'd1);
         check("bp_no_accept", {31'd0, in_ready}, 32'd0);
      end
      e = sb.pop_front();
      check("bp_sum", {16'd0, sum_out}, {16'd0, e.sum});
      check("bp_cout", {31'd0, c_out}, {31'd0, e.co});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      check("bp_release_busy", {31'd0, busy}, 32'd0);
      sb.push_back(model(16'h00AA, 16'h0055, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("late_accept_busy", {31'd0, busy}, 32'd1);
      collect("op_late", 1'b1);
      check("idle_retain_sum", {16'd0, sum_out}, 32'h00FF);

      // Reset in the second RUN cycle discards the operation.
      issue(16'h1234, 16'h1111, 1'b0);
      @(posedge clk); #2;
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_sum", {16'd0, sum_out}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'h0001, 16'h0002, 1'b0); collect("op_after_rst", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rca4_serial_seq.md
Name: rca4_serial_seq

Overview:
- Sequencer that drives the 4-bit ripple-carry adder `rca4` one nibble per clock and captures its results.
- Feeds `a`, `b` and `ci` into `rca4`; consumes `s` and `co`; chains the carry between nibbles.
- The team uses it to perform WIDTH-bit additions on the single small gate-level adder instead of a wide adder.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; number of `rca4` passes per operation; not overridden.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- c_in  in  1  carry-in for the whole operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  WIDTH  A+B+c_in, low WIDTH bits.
- c_out  out  1  unsigned carry-out of the MSB.
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - sum_out=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1 (once reset is released).
  - Internal operand regs, carry reg and nibble index are zeroed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a_in, b_in, c_in into operand regs and the carry reg; idx=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and operands are not re-sampled.
  - `rca4` inputs (combinational): a=A[idx*4+:4], b=B[idx*4+:4], ci=carry reg.
  - Each edge: write s into sum_reg[idx*4+:4]; carry reg <= co; idx <= idx+1.
  - On the edge where idx==NIBBLES-1: capture the last nibble, go to DONE, idx wraps to 0.
- DONE:
  - out_valid=1; sum_out, c_out (=carry reg) and ovf are stable.
  - ovf = (A[WIDTH-1]==B[WIDTH-1]) && (sum_reg[WIDTH-1]!=A[WIDTH-1]).
  - On an edge with out_ready=1: go to IDLE, out_valid drops.
  - out_ready=0 holds DONE and all outputs indefinitely.
- Latency:
  - Accept edge k → out_valid high after edge k+NIBBLES (WIDTH=16: 4 cycles).
  - One operation is in flight at a time; no accept in DONE.
  - Minimum issue interval is NIBBLES+2 cycles.
- sum_out/c_out/ovf:
  - Registered; they retain the last result in IDLE.
  - They change only on the final RUN capture.
  - They are not valid unless out_valid=1.
- Arithmetic: unsigned modulo 2^WIDTH; the carry from nibble i feeds nibble i+1 only through the carry reg; no combinational path from `co` to `ci`.
- Boundary cases:
  - NIBBLES=1: RUN lasts exactly one cycle.
  - An in_valid pulse during RUN/DONE is dropped; the producer must hold in_valid until in_ready.
  - Reset asserted mid-RUN or in DONE aborts the operation immediately; the result is discarded; out_valid=0 asynchronously.
  - idx counter width is clog2(NIBBLES) with a minimum of 1.

Decomposition:
- Shared package `rca_seq_pkg`:
  - NIB_W=4.
  - State enum {IDLE, RUN, DONE} with 2-bit encoding IDLE=0, RUN=1, DONE=2.
- Sub-module: existing `rca4`, instantiated once as the combinational datapath (ports a, b, ci, s, co).
- All sequencing, muxing and registers live in rca4_serial_seq.

Test Plan (WIDTH=16):
- 0x1234 + 0x4321, c_in=0 → out_valid 4 cycles after the accept edge; sum_out=0x5555, c_out=0, ovf=0.
- 0xFFFF + 0x0001, c_in=0 → sum_out=0x0000, c_out=1, ovf=0; carry ripples through all four nibble passes.
- 0x7FFF + 0x0001 → sum_out=0x8000, c_out=0, ovf=1.
- 0x8000 + 0x8000 → sum_out=0x0000, c_out=1, ovf=1.
- 0x0000 + 0xFFFF, c_in=1 → sum_out=0x0000, c_out=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum_out and busy stay constant.
  - Then out_ready=1 → IDLE next edge, in_ready=1.
  - A new operand presented during DONE is not accepted until IDLE.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle → out_valid=0, busy=0 and sum_out=0 immediately.
  - After release, 0x0001 + 0x0002 yields 0x0003 with no residue from the aborted operation.
